adam_rst_seq: RTL and testbench

Parametrised reset sequencer for ADAM FPGA tops. It combines a power-on hold with a debounced board reset button and a software reset request, and drives `NO_OUTS` reset outputs. Outputs release in index order, with a programmable stagger, so clock dividers, memories and the core leave reset deterministically. It sits between the board pins and the `ADAM_SEQ` reset fan-out, replacing ad-hoc per-board counters.

---
 rtl/adam_rst_pkg.sv | 25 ++
 rtl/adam_debounce.sv | 63 ++++++
 rtl/adam_rst_seq.sv | 205 ++++++++++++++++++++
 tb/tb_adam_rst_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/adam_rst_pkg.sv
// adam_rst_pkg: shared types for the ADAM reset sequencer.
// Holds the sequencer state and reset-cause encodings plus a small sizing helper.
package adam_rst_pkg;

   // Sequencer phases: everything held, staggered release, fully released.
   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_t;

   // Last reset cause as presented on the cause output.
   typedef enum logic [1:0] {
      POR = 2'b00,
      BTN = 2'b01,
      SW  = 2'b10,
      WDT = 2'b11
   } cause_t;

   // Larger of two integers, used to size the shared hold/stagger counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/adam_debounce.sv
// adam_debounce: two-flop synchroniser followed by a level debouncer.
// The output is normalised to active-high: db_o = 1 means "button pressed"
// regardless of the board polarity selected by ACTIVE_HIGH.
module adam_debounce #(
   parameter int CYCLES      = 1024,
   parameter int ACTIVE_HIGH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic db_o
);

   // Raw pin level that corresponds to "not pressed".
   localparam logic IDLE_LVL = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
   localparam int   DB_W     = $clog2(CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(CYCLES - 1);

   logic [1:0]      sync_q;
   logic            lvl;
   logic [DB_W-1:0] cnt_q, cnt_d;
   logic            db_q, db_d;

   // Synchroniser: the pin is asynchronous, so it passes two flops first.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {2{IDLE_LVL}};
      end else begin
         sync_q <= {sync_q[0], btn_i};
      end
   end

   // Synchronised level mapped to pressed = 1.
   assign lvl = (ACTIVE_HIGH != 0) ? sync_q[1] : ~sync_q[1];

   // Debounce: accept a new level only after CYCLES consecutive differing samples.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (lvl != db_q) begin
         if (cnt_q == DB_LAST) begin
            db_d  = lvl;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + DB_W'(1);
         end
      end
   end

   // Debouncer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         db_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         db_q  <= db_d;
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/adam_rst_seq.sv
// adam_rst_seq: reset sequencer for ADAM FPGA tops.
// Combines power-on, a debounced board button and a software request, then
// releases NO_OUTS reset outputs in index order with a fixed stagger.
// Optional watchdog: define ADAM_RST_SEQ_WDT_EN to add the kick port,
// the WDT_CYCLES parameter and the watchdog reset cause.
module adam_rst_seq
   import adam_rst_pkg::*;
#(
   parameter int NO_OUTS         = 3,
   parameter int HOLD_CYCLES     = 16,
   parameter int STAGGER_CYCLES  = 4,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int BTN_ACTIVE_HIGH = 1
`ifdef ADAM_RST_SEQ_WDT_EN
  ,parameter int WDT_CYCLES      = 1 << 24
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn,
   input  logic               sw_req,
`ifdef ADAM_RST_SEQ_WDT_EN
   input  logic               kick,
`endif
   output logic [NO_OUTS-1:0] rst_out,
   output logic               done,
   output logic [1:0]         cause
);

   // One counter is shared by the hold and stagger phases.
   localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);
   localparam int IDX_W = (NO_OUTS > 1) ? $clog2(NO_OUTS) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NO_OUTS - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NO_OUTS-1:0] rst_out_q, rst_out_d;
   logic               done_q, done_d;
   cause_t             cause_q, cause_d;
   logic               db_prev_q;

   logic               btn_db;
   logic               btn_rise;
   logic               wdt_expire;
   logic               evt;
   logic               rel_fire;
   logic [IDX_W-1:0]   rel_idx;
   logic [NO_OUTS-1:0] clr_vec;

   adam_debounce #(
      .CYCLES      (DEBOUNCE_CYCLES),
      .ACTIVE_HIGH (BTN_ACTIVE_HIGH)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn),
      .db_o  (btn_db)
   );

   // Only a new press restarts the sequence; holding the button merely stalls HOLD.
   assign btn_rise = btn_db & ~db_prev_q;

`ifdef ADAM_RST_SEQ_WDT_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] wdt_q, wdt_d;

   // Expiry fires on the edge where the count would reach WDT_CYCLES, unless kicked.
   assign wdt_expire = (state_q == RUN) && !kick && (wdt_q == WDT_LAST);

   // Watchdog counts only while fully released; kicks and any restart clear it.
   always_comb begin
      if ((state_q != RUN) || kick || evt) begin
         wdt_d = '0;
      end else begin
         wdt_d = wdt_q + WDT_W'(1);
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`else
   assign wdt_expire = 1'b0;
`endif

   assign evt = btn_rise | sw_req | wdt_expire;

   // Sequencer next state: restarts on any event, otherwise hold then stagger out.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      done_d   = done_q;
      cause_d  = cause_q;
      rel_fire = 1'b0;
      rel_idx  = idx_q;
      if (evt) begin
         state_d = HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         done_d  = 1'b0;
         // Button wins over software, software over watchdog.
         if (btn_rise) begin
            cause_d = BTN;
         end else if (sw_req) begin
            cause_d = SW;
         end else begin
            cause_d = WDT;
         end
      end else begin
         case (state_q)
            HOLD: begin
               if (btn_db) begin
                  // Timing restarts from the edge the debounced button clears.
                  cnt_d = '0;
               end else if (cnt_q == HOLD_LAST) begin
                  rel_fire = 1'b1;
                  rel_idx  = '0;
                  cnt_d    = '0;
                  if (NO_OUTS == 1) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RELEASE;
                     idx_d   = IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (cnt_q == STAG_LAST) begin
                  rel_fire = 1'b1;
                  rel_idx  = idx_q;
                  cnt_d    = '0;
                  if (idx_q == IDX_LAST) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               cnt_d = '0;
            end
            default: begin
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   // Per-output release strobe: one bit clears when its index is released.
   genvar gi;
   generate
      for (gi = 0; gi < NO_OUTS; gi++) begin : g_clr
         assign clr_vec[gi] = rel_fire && (rel_idx == IDX_W'(gi));
      end
   endgenerate

   // Already-released outputs reassert at once on any restart.
   assign rst_out_d = evt ? {NO_OUTS{1'b1}} : (rst_out_q & ~clr_vec);

   // Sequencer registers; cause is only cleared by power-on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HOLD;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= {NO_OUTS{1'b1}};
         done_q    <= 1'b0;
         cause_q   <= POR;
         db_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         done_q    <= done_d;
         cause_q   <= cause_d;
         db_prev_q <= btn_db;
      end
   end

   assign rst_out = rst_out_q;
   assign done    = done_q;
   assign cause   = cause_q;

endmodule

// File: tb/tb_adam_rst_seq.sv
// tb_adam_rst_seq: directed self-checking bench for adam_rst_seq.
// Uses NO_OUTS=3, HOLD_CYCLES=16, STAGGER_CYCLES=4, DEBOUNCE_CYCLES=8.
// With ADAM_RST_SEQ_WDT_EN defined it also exercises the watchdog (WDT_CYCLES=100).
module tb_adam_rst_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic       sw_req;
`ifdef ADAM_RST_SEQ_WDT_EN
   logic       kick;
`endif
   logic [2:0] rst_out;
   logic       done;
   logic [1:0] cause;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   adam_rst_seq #(
      .NO_OUTS         (3),
      .HOLD_CYCLES     (16),
      .STAGGER_CYCLES  (4),
      .DEBOUNCE_CYCLES (8),
      .BTN_ACTIVE_HIGH (1)
`ifdef ADAM_RST_SEQ_WDT_EN
     ,.WDT_CYCLES      (100)
`endif
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn),
      .sw_req  (sw_req),
`ifdef ADAM_RST_SEQ_WDT_EN
      .kick    (kick),
`endif
      .rst_out (rst_out),
      .done    (done),
      .cause   (cause)
   );

   // Advance n rising edges, leaving time 1 unit past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_st(input string tag, input logic [2:0] r, input logic d, input logic [1:0] c);
      chk({tag, "/rst_out"}, 32'(rst_out), 32'(r));
      chk({tag, "/done"},    32'(done),    32'(d));
      chk({tag, "/cause"},   32'(cause),   32'(c));
      $display("step %-14s rst_out=%b done=%b cause=%b", tag, rst_out, done, cause);
   endtask

   initial begin
      rst    = 1'b1;
      btn    = 1'b0;
      sw_req = 1'b0;
`ifdef ADAM_RST_SEQ_WDT_EN
      kick   = 1'b0;
`endif
      // Power-on: last rst edge is edge r.
      tick(5);
      expect_st("por_hold", 3'b111, 1'b0, 2'b00);
      rst = 1'b0;
      tick(15); expect_st("por_p15", 3'b111, 1'b0, 2'b00);
      tick(1);  expect_st("por_p16", 3'b110, 1'b0, 2'b00);
      tick(3);  expect_st("por_p19", 3'b110, 1'b0, 2'b00);
      tick(1);  expect_st("por_p20", 3'b100, 1'b0, 2'b00);
      tick(3);  expect_st("por_p23", 3'b100, 1'b0, 2'b00);
      tick(1);  expect_st("por_p24", 3'b000, 1'b1, 2'b00);
      tick(3);  expect_st("por_run", 3'b000, 1'b1, 2'b00);

      // Software request in RUN.
      sw_req = 1'b1; tick(1); sw_req = 1'b0;
      expect_st("sw_k", 3'b111, 1'b0, 2'b10);
      tick(15); expect_st("sw_p15", 3'b111, 1'b0, 2'b10);
      tick(1);  expect_st("sw_p16", 3'b110, 1'b0, 2'b10);
      tick(4);  expect_st("sw_p20", 3'b100, 1'b0, 2'b10);
      tick(4);  expect_st("sw_p24", 3'b000, 1'b1, 2'b10);

      // Short glitch is filtered.
      btn = 1'b1; tick(5); btn = 1'b0;
      tick(20); expect_st("glitch", 3'b000, 1'b1, 2'b10);

      // Long press: 2 sync + 8 debounce + 1 edges to assert.
      btn = 1'b1;
      tick(10); expect_st("btn_p10", 3'b000, 1'b1, 2'b10);
      tick(1);  expect_st("btn_p11", 3'b111, 1'b0, 2'b01);
      tick(19); expect_st("btn_held", 3'b111, 1'b0, 2'b01);
      btn = 1'b0;
      // Debounced level falls 10 edges after release; first output 16 edges later.
      tick(25); expect_st("btn_rel25", 3'b111, 1'b0, 2'b01);
      tick(1);  expect_st("btn_rel26", 3'b110, 1'b0, 2'b01);
      tick(4);  expect_st("btn_rel30", 3'b100, 1'b0, 2'b01);
      tick(4);  expect_st("btn_rel34", 3'b000, 1'b1, 2'b01);

      // Software request in the middle of a release restarts everything.
      sw_req = 1'b1; tick(1); sw_req = 1'b0;
      expect_st("mid_k", 3'b111, 1'b0, 2'b10);
      tick(17); expect_st("mid_p17", 3'b110, 1'b0, 2'b10);
      sw_req = 1'b1; tick(1); sw_req = 1'b0;
      expect_st("mid_p18", 3'b111, 1'b0, 2'b10);
      tick(15); expect_st("mid_r15", 3'b111, 1'b0, 2'b10);
      tick(1);  expect_st("mid_r16", 3'b110, 1'b0, 2'b10);
      tick(4);  expect_st("mid_r20", 3'b100, 1'b0, 2'b10);
      tick(4);  expect_st("mid_r24", 3'b000, 1'b1, 2'b10);

      // Debounced rise coincides with sw_req: button cause wins.
      btn = 1'b1;
      tick(10);
      sw_req = 1'b1; tick(1); sw_req = 1'b0; btn = 1'b0;
      expect_st("simul", 3'b111, 1'b0, 2'b01);
      tick(25); expect_st("simul_r25", 3'b111, 1'b0, 2'b01);
      tick(1);  expect_st("simul_r26", 3'b110, 1'b0, 2'b01);
      tick(4);  expect_st("simul_r30", 3'b100, 1'b0, 2'b01);
      tick(4);  expect_st("simul_r34", 3'b000, 1'b1, 2'b01);

`ifdef ADAM_RST_SEQ_WDT_EN
      // Watchdog without kicks fires 100 edges after done.
      sw_req = 1'b1; tick(1); sw_req = 1'b0;
      tick(24); expect_st("wdt_done", 3'b000, 1'b1, 2'b10);
      tick(99); expect_st("wdt_p99", 3'b000, 1'b1, 2'b10);
      tick(1);  expect_st("wdt_fire", 3'b111, 1'b0, 2'b11);
      tick(24); expect_st("wdt_redone", 3'b000, 1'b1, 2'b11);
      // Regular kicks keep it quiet.
      for (int i = 0; i < 1000; i++) begin
         kick = (i % 50 == 0);
         tick(1);
      end
      kick = 1'b0;
      expect_st("wdt_kicked", 3'b000, 1'b1, 2'b11);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
